// File: rtl/sysid_checker.sv
// sysid_checker: Avalon-MM read master that samples the system-ID slave
// (ID word at address 0, timestamp word at address 1) NUM_SAMPLES times,
// checks that repeated samples agree and compares them with the expected
// build constants. Results are held until the next start or reset.
//
// Build option: define SYSID_CHECKER_TS_CHECK_EN to include the timestamp
// in the pass equation and drive ts_mismatch. Without it the timestamp is
// still read, captured and stability-checked, but ts_mismatch stays 0.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start, no results yet
// RD_ID     | read strobe with address 0 (ID word)
// WAIT_ID   | counting READ_LATENCY cycles, capture ID on the last one
// RD_TS     | read strobe with address 1 (timestamp word)
// WAIT_TS   | counting READ_LATENCY cycles, capture timestamp on the last
// COMPARE   | one cycle to evaluate the mismatch flags and pass
// DONE      | results valid and held, start launches a new check

module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1328238288,
  parameter int          READ_LATENCY       = 1,
  parameter int          NUM_SAMPLES        = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        sysid_address,
  output logic        sysid_read,
  input  logic [31:0] sysid_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        unstable,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ID   = 3'd1,
    WAIT_ID = 3'd2,
    RD_TS   = 3'd3,
    WAIT_TS = 3'd4,
    COMPARE = 3'd5,
    DONE    = 3'd6
  } state_t;

`ifdef SYSID_CHECKER_TS_CHECK_EN
  localparam logic TS_CHECK_EN = 1'b1;
`else
  localparam logic TS_CHECK_EN = 1'b0;
`endif

  // Latency timer reload value: the capture happens when the timer reaches
  // zero, so a latency of N needs N-1 loaded at the read strobe.
  localparam logic [2:0] LAT_LOAD    = (READ_LATENCY > 0) ? 3'(READ_LATENCY - 1) : 3'd0;
  localparam logic       ZERO_LAT    = (READ_LATENCY == 0);
  localparam logic [3:0] LAST_SAMPLE = 4'(NUM_SAMPLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  lat_cnt;
  logic [3:0]  sample_cnt;
  logic        last_pass;
  logic        cap_id;
  logic        cap_ts;
  logic        launch;
  logic        id_mm_c;
  logic        ts_mm_c;

  assign last_pass = (sample_cnt == LAST_SAMPLE);
  assign id_mm_c   = (id_value != EXPECTED_ID);
  assign ts_mm_c   = TS_CHECK_EN & (ts_value != EXPECTED_TIMESTAMP);

  assign busy = (state != IDLE) && (state != DONE);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic, read strobe and capture enables.
  always_comb begin
    state_nxt  = state;
    sysid_read = 1'b0;
    cap_id     = 1'b0;
    cap_ts     = 1'b0;
    launch     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          launch    = 1'b1;
          state_nxt = RD_ID;
        end
      end
      RD_ID: begin
        sysid_read = 1'b1;
        if (ZERO_LAT) begin
          cap_id    = 1'b1;
          state_nxt = RD_TS;
        end else begin
          state_nxt = WAIT_ID;
        end
      end
      WAIT_ID: begin
        if (lat_cnt == 3'd0) begin
          cap_id    = 1'b1;
          state_nxt = RD_TS;
        end
      end
      RD_TS: begin
        sysid_read = 1'b1;
        if (ZERO_LAT) begin
          cap_ts    = 1'b1;
          state_nxt = last_pass ? COMPARE : RD_ID;
        end else begin
          state_nxt = WAIT_TS;
        end
      end
      WAIT_TS: begin
        if (lat_cnt == 3'd0) begin
          cap_ts    = 1'b1;
          state_nxt = last_pass ? COMPARE : RD_ID;
        end
      end
      COMPARE: begin
        state_nxt = DONE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Read-latency down-counter, reloaded on every read strobe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lat_cnt <= 3'd0;
    end else if (sysid_read) begin
      lat_cnt <= LAT_LOAD;
    end else if (lat_cnt != 3'd0) begin
      lat_cnt <= lat_cnt - 3'd1;
    end
  end

  // Sample-pass counter, advanced after each timestamp capture.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sample_cnt <= 4'd0;
    end else if (launch) begin
      sample_cnt <= 4'd0;
    end else if (cap_ts && !last_pass) begin
      sample_cnt <= sample_cnt + 4'd1;
    end
  end

  // Word select, set on entry to a read state and held otherwise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sysid_address <= 1'b0;
    end else if (state_nxt == RD_ID) begin
      sysid_address <= 1'b0;
    end else if (state_nxt == RD_TS) begin
      sysid_address <= 1'b1;
    end
  end

  // Captures plus the sticky stability flag; the previous capture of each
  // word is still held in id_value/ts_value when the new sample arrives.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      id_value <= 32'd0;
      ts_value <= 32'd0;
      unstable <= 1'b0;
    end else begin
      if (launch) begin
        unstable <= 1'b0;
      end
      if (cap_id) begin
        id_value <= sysid_readdata;
        if ((sample_cnt != 4'd0) && (sysid_readdata != id_value)) begin
          unstable <= 1'b1;
        end
      end
      if (cap_ts) begin
        ts_value <= sysid_readdata;
        if ((sample_cnt != 4'd0) && (sysid_readdata != ts_value)) begin
          unstable <= 1'b1;
        end
      end
    end
  end

  // Result flags: cleared on launch, evaluated in COMPARE, held in DONE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      id_mismatch <= 1'b0;
      ts_mismatch <= 1'b0;
      pass        <= 1'b0;
    end else if (launch) begin
      id_mismatch <= 1'b0;
      ts_mismatch <= 1'b0;
      pass        <= 1'b0;
    end else if (state == COMPARE) begin
      id_mismatch <= id_mm_c;
      ts_mismatch <= ts_mm_c;
      pass        <= !(id_mm_c | ts_mm_c | unstable);
    end
  end

endmodule
